// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised line, start/data/stop FSM, LSB-first payload.
// Latency: valid/frame_err pulse one cycle after the stop-bit sample point.
// Backpressure: none; consumer must take uart_rx_data while uart_rx_valid is high.
//
// Ports:
//   clk, resetn (synchronous, active low)
//   uart_rxd           serial line in (async, idles high)
//   uart_rx_en         receive enable; dropping it mid-frame aborts silently
//   uart_rx_busy       high whenever the FSM is outside IDLE
//   uart_rx_valid      one-cycle pulse, good frame; uart_rx_data updates with it
//   uart_rx_data       last good payload, held between pulses
//   uart_rx_frame_err  one-cycle pulse, stop bit sampled low
//
// Build option: define UART_RX_MAJORITY_EN to decide each data/stop bit by a
// 2-of-3 vote of the samples at counter CYCLES_PER_BIT-3..-1 (needs
// CYCLES_PER_BIT >= 4). Timing is the same in both builds.
module uart_rx #(
    parameter int BIT_RATE     = 9600,
    parameter int CLK_HZ       = 50_000_000,
    parameter int PAYLOAD_BITS = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic                    uart_rx_busy,
    output logic                    uart_rx_valid,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_rx_frame_err
);

    localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
    localparam int CNT_W          = $clog2(CYCLES_PER_BIT + 1);
    localparam int IDX_W          = $clog2(PAYLOAD_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [IDX_W-1:0]        idx, idx_nxt;
    logic [PAYLOAD_BITS-1:0] shift, shift_nxt;
    logic [PAYLOAD_BITS-1:0] data_nxt;
    logic [PAYLOAD_BITS:0]   shift_ext;
    logic                    valid_nxt, ferr_nxt;

    // Synchroniser plus one-cycle history for falling-edge detection.
    logic rx_s1, rxs, rxs_prev;
    logic bit_val;
    logic bit_last;

    assign bit_last = (cnt == CNT_LAST);

`ifdef UART_RX_MAJORITY_EN
    localparam logic [CNT_W-1:0] CNT_V0 = CNT_W'(CYCLES_PER_BIT - 3);
    localparam logic [CNT_W-1:0] CNT_V1 = CNT_W'(CYCLES_PER_BIT - 2);
    logic vote0, vote1;

    // The two earlier votes are captured as the counter passes them; the
    // third is rxs itself at the decision point.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            vote0 <= 1'b1;
            vote1 <= 1'b1;
        end else begin
            if (cnt == CNT_V0) vote0 <= rxs;
            if (cnt == CNT_V1) vote1 <= rxs;
        end
    end

    assign bit_val = (vote0 & vote1) | (vote0 & rxs) | (vote1 & rxs);
`else
    assign bit_val = rxs;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_s1             <= 1'b1;
            rxs               <= 1'b1;
            rxs_prev          <= 1'b1;
            state             <= IDLE;
            cnt               <= '0;
            idx               <= '0;
            shift             <= '0;
            uart_rx_data      <= '0;
            uart_rx_valid     <= 1'b0;
            uart_rx_frame_err <= 1'b0;
        end else begin
            rx_s1             <= uart_rxd;
            rxs               <= rx_s1;
            rxs_prev          <= rxs;
            state             <= state_nxt;
            cnt               <= cnt_nxt;
            idx               <= idx_nxt;
            shift             <= shift_nxt;
            uart_rx_data      <= data_nxt;
            uart_rx_valid     <= valid_nxt;
            uart_rx_frame_err <= ferr_nxt;
        end
    end

    // New bit enters at the MSB so an LSB-first stream ends up in order.
    assign shift_ext = {bit_val, shift};

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        shift_nxt = shift;
        data_nxt  = uart_rx_data;
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                idx_nxt = '0;
                // Edge rather than level, so a stuck-low line never restarts.
                if (uart_rx_en && !rxs && rxs_prev) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_nxt   = '0;
                    state_nxt = rxs ? IDLE : DATA;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            DATA: begin
                if (bit_last) begin
                    cnt_nxt   = '0;
                    shift_nxt = shift_ext[PAYLOAD_BITS:1];
                    if (idx == IDX_LAST) begin
                        idx_nxt   = '0;
                        state_nxt = STOP;
                    end else begin
                        idx_nxt = idx + IDX_ONE;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            STOP: begin
                if (bit_last) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                    if (bit_val) begin
                        valid_nxt = 1'b1;
                        data_nxt  = shift;
                    end else begin
                        ferr_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Disable wins over everything: drop the frame without any pulse.
        if (state != IDLE && !uart_rx_en) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
            valid_nxt = 1'b0;
            ferr_nxt  = 1'b0;
            data_nxt  = uart_rx_data;
        end
    end

    assign uart_rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomised frames at 10 clocks per bit against a frame-level model.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       uart_rxd = 1'b1;
    logic       uart_rx_en = 1'b1;
    logic       uart_rx_busy;
    logic       uart_rx_valid;
    logic [7:0] uart_rx_data;
    logic       uart_rx_frame_err;

    uart_rx #(
        .BIT_RATE    (100_000),
        .CLK_HZ      (1_000_000),
        .PAYLOAD_BITS(8)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .uart_rxd         (uart_rxd),
        .uart_rx_en       (uart_rx_en),
        .uart_rx_busy     (uart_rx_busy),
        .uart_rx_valid    (uart_rx_valid),
        .uart_rx_data     (uart_rx_data),
        .uart_rx_frame_err(uart_rx_frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Output monitor: everything the DUT reports, sampled on the falling edge.
    logic [7:0] rx_q[$];
    int n_valid = 0;
    int n_ferr  = 0;
    int n_both  = 0;

    always @(negedge clk) begin
        if (uart_rx_valid) begin
            rx_q.push_back(uart_rx_data);
            n_valid++;
        end
        if (uart_rx_frame_err) n_ferr++;
        if (uart_rx_valid && uart_rx_frame_err) n_both++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            uart_rxd = 1'b1;
        end
    endtask

    // Drives the first ncyc cycles of a 10-bit frame (start, 8 data LSB first,
    // stop). glitch_bit >= 0 inverts one cycle in the middle of that data bit.
    task automatic drive_frame(input logic [7:0] d, input logic stop_v,
                               input int glitch_bit, input int ncyc);
        logic [9:0] bits;
        logic v;
        bits = {stop_v, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            for (int j = 0; j < 10; j++) begin
                if (b * 10 + j >= ncyc) return;
                @(negedge clk);
                v = bits[b];
                if (glitch_bit >= 0 && b == glitch_bit + 1 && j == 5) v = ~v;
                uart_rxd = v;
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int glitch_bit);
        drive_frame(d, stop_v, glitch_bit, 100);
    endtask

    function automatic logic [7:0] pop_rx();
        logic [7:0] r;
        r = 8'hxx;
        if (rx_q.size() > 0) r = rx_q.pop_front();
        return r;
    endfunction

    initial begin
        int v0, f0, busy_cnt;
        logic [7:0] exp_q[$];
        logic [7:0] last_data;
        logic [7:0] d;
        logic       stp;
        int exp_ferr;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", uart_rx_busy, 0);
        check("rst_valid", uart_rx_valid, 0);
        check("rst_ferr", uart_rx_frame_err, 0);
        check("rst_data", uart_rx_data, 0);
        resetn = 1'b1;
        idle_cycles(10);

        // Good frame 0xA5
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'hA5, 1'b1, -1);
        idle_cycles(20);
        check("a5_nvalid", n_valid - v0, 1);
        check("a5_data", pop_rx(), 8'hA5);
        check("a5_ferr", n_ferr - f0, 0);

        // Framing error 0x3C, line then stuck low
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'h3C, 1'b0, -1);
        busy_cnt = 0;
        repeat (50) begin
            @(negedge clk);
            busy_cnt += int'(uart_rx_busy);
            uart_rxd = 1'b0;
        end
        check("ferr_nferr", n_ferr - f0, 1);
        check("ferr_nvalid", n_valid - v0, 0);
        check("ferr_data_held", uart_rx_data, 8'hA5);
        check("ferr_busy_low", busy_cnt, 0);
        idle_cycles(20);

        // 3-cycle low glitch: false start
        v0 = n_valid; f0 = n_ferr; busy_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            busy_cnt += int'(uart_rx_busy);
            uart_rxd = (i < 3) ? 1'b0 : 1'b1;
        end
        check("glitch_busy_cycles", busy_cnt, 5);
        check("glitch_nvalid", n_valid - v0, 0);
        check("glitch_nferr", n_ferr - f0, 0);
        check("glitch_data_held", uart_rx_data, 8'hA5);

        // Enable dropped during data bit 4 of 0xFF
        v0 = n_valid; f0 = n_ferr;
        drive_frame(8'hFF, 1'b1, -1, 52);
        check("en_abort_busy_before", uart_rx_busy, 1);
        @(negedge clk);
        uart_rx_en = 1'b0;
        @(negedge clk);
        check("en_abort_busy", uart_rx_busy, 0);
        uart_rxd = 1'b1;
        idle_cycles(60);
        uart_rx_en = 1'b1;
        check("en_abort_pulses", (n_valid - v0) + (n_ferr - f0), 0);
        check("en_abort_data", uart_rx_data, 8'hA5);
        idle_cycles(5);
        send_frame(8'h12, 1'b1, -1);
        idle_cycles(20);
        check("en_after_data", pop_rx(), 8'h12);

        // Reset during data bit 4 of 0xFF
        v0 = n_valid; f0 = n_ferr;
        drive_frame(8'hFF, 1'b1, -1, 52);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("rst_abort_busy", uart_rx_busy, 0);
        check("rst_abort_data", uart_rx_data, 0);
        uart_rxd = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        idle_cycles(60);
        check("rst_abort_pulses", (n_valid - v0) + (n_ferr - f0), 0);
        send_frame(8'h12, 1'b1, -1);
        idle_cycles(20);
        check("rst_after_data", pop_rx(), 8'h12);

        // Back-to-back 0x00, 0xFF
        v0 = n_valid;
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        idle_cycles(20);
        check("b2b_nvalid", n_valid - v0, 2);
        check("b2b_first", pop_rx(), 8'h00);
        check("b2b_second", pop_rx(), 8'hFF);

        // One-cycle high glitch at the bit-2 sample point of 0x00
        send_frame(8'h00, 1'b1, 2);
        idle_cycles(20);
`ifdef UART_RX_MAJORITY_EN
        check("vote_glitch_data", pop_rx(), 8'h00);
`else
        check("vote_glitch_data", pop_rx(), 8'h04);
`endif

        // Random frames: good stop -> payload delivered in order, bad stop ->
        // one error and the held payload stays the last good one.
        last_data = uart_rx_data;
        exp_ferr = 0;
        v0 = n_valid; f0 = n_ferr;
        rx_q.delete();
        for (int k = 0; k < 20; k++) begin
            d   = 8'($urandom_range(0, 255));
            stp = ($urandom_range(0, 3) != 0);
            send_frame(d, stp, -1);
            if (stp) begin
                exp_q.push_back(d);
                last_data = d;
            end else begin
                exp_ferr++;
            end
            idle_cycles(stp ? $urandom_range(0, 6) : $urandom_range(3, 9));
        end
        idle_cycles(20);
        check("rand_nvalid", n_valid - v0, exp_q.size());
        check("rand_nferr", n_ferr - f0, exp_ferr);
        while (exp_q.size() > 0) begin
            check("rand_data", pop_rx(), exp_q.pop_front());
        end
        check("rand_last_data", uart_rx_data, last_data);
        check("valid_ferr_exclusive", n_both, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: p19_uart_rx

Interface
REQ-001 The block SHALL have parameter BIT_RATE, default 9600, which is the line bit rate in bits/s.
REQ-002 The block SHALL have parameter CLK_HZ, default 50_000_000, which is the clk frequency in Hz.
REQ-003 The block SHALL have parameter PAYLOAD_BITS, default 8, which is the number of data bits per frame.
REQ-004 The block SHALL have port clk: input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port resetn: input, 1 bit, a synchronous active-low reset.
REQ-006 The block SHALL have port uart_rxd: input, 1 bit, the asynchronous serial receive line; it idles high.
REQ-007 The block SHALL have port uart_rx_en: input, 1 bit, the receive enable.
REQ-008 The block SHALL have port uart_rx_busy: output, 1 bit, which is high while a frame is in progress.
REQ-009 The block SHALL have port uart_rx_valid: output, 1 bit, a one-cycle pulse marking a good frame.
REQ-010 The block SHALL have port uart_rx_data: output, PAYLOAD_BITS bits, the last received payload.
REQ-011 The block SHALL have port uart_rx_frame_err: output, 1 bit, a one-cycle pulse marking a bad stop bit.

Function
REQ-012 The block SHALL use CYCLES_PER_BIT = CLK_HZ/BIT_RATE (integer division) and HALF_BIT = CYCLES_PER_BIT/2, with the counter wide enough to hold CYCLES_PER_BIT.
REQ-013 uart_rxd SHALL pass through a two-flop synchronizer; the FSM and the edge detect SHALL use only the second flop ("rxs").
REQ-014 The FSM states SHALL be IDLE, START, DATA and STOP; uart_rx_busy SHALL be high in every state except IDLE.
REQ-015 In IDLE, a start SHALL be detected when uart_rx_en=1, rxs=0 and rxs was 1 on the previous cycle; the FSM then goes to START with the counter at 0.
REQ-016 A constant-low line in IDLE SHALL never produce a start.
REQ-017 In START, the counter SHALL increment each cycle; when it reaches HALF_BIT-1, rxs is sampled: 1 -> IDLE (false start, no output pulse); 0 -> DATA with the counter cleared.
REQ-018 In DATA, a bit SHALL be sampled when the counter reaches CYCLES_PER_BIT-1 and then the counter cleared; bits are LSB first and shifted in at the MSB.
REQ-019 After PAYLOAD_BITS samples in DATA, the FSM SHALL go to STOP.
REQ-020 In STOP, the stop bit SHALL be sampled at counter CYCLES_PER_BIT-1, and the FSM SHALL return to IDLE on the next cycle.
REQ-021 If the stop sample is 1, uart_rx_valid SHALL pulse high for exactly 1 cycle, on the cycle after the sample, and uart_rx_data SHALL update on that same cycle.
REQ-022 If the stop sample is 0, uart_rx_frame_err SHALL pulse for 1 cycle, uart_rx_valid SHALL stay 0 and uart_rx_data SHALL be unchanged.
REQ-023 Because of the falling-edge rule (REQ-015), no new frame SHALL start until the line has returned high.
REQ-024 uart_rx_data SHALL hold its value between valid pulses and SHALL NOT change on a false start, an abort or a framing error.
REQ-025 If uart_rx_en is deasserted in any non-IDLE state, the FSM SHALL go to IDLE on the next edge, with no valid or error pulse.
REQ-026 uart_rx_valid and uart_rx_frame_err SHALL never be high together.
REQ-027 The block SHALL have no backpressure; the consumer samples uart_rx_data when uart_rx_valid is high.

Reset
REQ-028 When resetn=0 at a clk edge, the FSM SHALL go to IDLE and the counter, bit index and shift register SHALL clear.
REQ-029 During reset, uart_rx_data SHALL be 0, uart_rx_valid, uart_rx_frame_err and uart_rx_busy SHALL be 0, and both synchronizer flops and the previous-rxs flop SHALL be 1.
REQ-030 A reset during a frame SHALL abort the frame with no pulse, and the block SHALL re-arm only on a fresh falling edge after reset is released.

Configuration
REQ-031 When UART_RX_MAJORITY_EN is defined, each data and stop bit SHALL be decided by a 2-of-3 majority of rxs at counter values CYCLES_PER_BIT-3, -2 and -1, with the decision at -1; this SHALL require CYCLES_PER_BIT >= 4.
REQ-032 When UART_RX_MAJORITY_EN is undefined, each bit SHALL be a single rxs sample at CYCLES_PER_BIT-1 and the vote logic SHALL be absent.
REQ-033 The start-bit check SHALL be a single sample in both builds, and timing SHALL be identical in both builds.

Verification (CLK_HZ=1_000_000, BIT_RATE=100_000, so CYCLES_PER_BIT=10, HALF_BIT=5)
REQ-034 Send 0xA5 with a 1 stop bit at 10 cycles/bit -> exactly one uart_rx_valid pulse, uart_rx_data=0xA5, uart_rx_frame_err never high.
REQ-035 Send 0x3C with the stop bit held 0, then hold the line low for 50 cycles -> one uart_rx_frame_err pulse, no valid, uart_rx_data unchanged, busy stays 0 until a new high-to-low edge.
REQ-036 Drive a 3-cycle low glitch in IDLE -> busy high for about 5 cycles then 0, with no valid and no error.
REQ-037 Deassert uart_rx_en, or assert resetn=0, during data bit 4 of 0xFF -> IDLE next cycle with no pulses; a following 0x12 frame is received correctly.
REQ-038 Send back-to-back frames 0x00 then 0xFF with no idle gap -> two valid pulses carrying 0x00 then 0xFF.
REQ-039 With UART_RX_MAJORITY_EN defined, send 0x00 with a 1-cycle high glitch at the bit-2 sample point -> uart_rx_data=0x00; without the macro -> uart_rx_data=0x04.
